// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: shares the instruction memory port between a byte-serial program loader and CPU fetch.
// Define IMEM_LOAD_CHECKSUM_EN to build the XOR checksum of loaded words; otherwise load_checksum is 0.
module imem_load_ctrl #(
   parameter int          DEPTH     = 64,
   parameter int          ADDR_W    = 6,
   parameter logic [31:0] HALT_WORD = 32'hB4221820,
   parameter logic [31:0] NOP_WORD  = 32'h00000020,
   parameter bit          BOOT_RUN  = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load_start,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   input  logic [31:0]       i_fetch_addr,
   output logic [31:0]       o_inst_out,
   output logic              o_cpu_stall,
   output logic              o_cpu_hold_reset,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata,
   output logic [1:0]        o_state_out,
   output logic              o_load_err,
   output logic              o_addr_err,
   output logic [31:0]       o_load_checksum
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALTED = 2'd3} state_t;
   state_t            r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [1:0]        r_byte_cnt;
   logic [23:0]       r_word_buf;
   logic              r_load_err;
   logic              r_addr_err;
   logic              w_accept;
   logic              w_wr;
   logic              w_in_range;
   logic              w_unused;
   logic [31:0]       w_word;

   assign w_in_range       = i_fetch_addr[31:ADDR_W+2] == '0;
   assign w_unused         = ^i_fetch_addr[1:0];
   assign o_rx_ready       = (r_state == LOAD) && !i_load_start;
   assign w_accept         = o_rx_ready && i_rx_valid;
   assign w_word           = {r_word_buf, i_rx_data};
   assign w_wr             = w_accept && (r_byte_cnt == 2'd3);
   assign o_mem_we         = w_wr;
   assign o_mem_wdata      = w_word;
   assign o_mem_addr       = (r_state == LOAD) ? r_wr_ptr : i_fetch_addr[ADDR_W+1:2];
   assign o_inst_out       = (r_state == RUN && w_in_range) ? i_mem_rdata : NOP_WORD;
   assign o_cpu_hold_reset = (r_state == IDLE) || (r_state == LOAD);
   assign o_cpu_stall      = r_state != RUN;
   assign o_state_out      = r_state;
   assign o_load_err       = r_load_err;
   assign o_addr_err       = r_addr_err;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= BOOT_RUN ? RUN : IDLE;
         r_wr_ptr   <= '0;
         r_byte_cnt <= '0;
         r_word_buf <= '0;
         r_load_err <= 1'b0;
         r_addr_err <= 1'b0;
      end else if (i_load_start) begin
         r_state    <= LOAD;
         r_wr_ptr   <= '0;
         r_byte_cnt <= '0;
         r_word_buf <= '0;
         r_load_err <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         case (r_state)
            LOAD: if (w_accept) begin
               r_word_buf <= w_word[23:0];
               r_byte_cnt <= r_byte_cnt + 2'd1;
               if (w_wr) begin
                  r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                  if (w_word == HALT_WORD) r_state <= RUN;
                  else if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
                     r_load_err <= 1'b1;
                     r_state    <= IDLE;
                  end
               end
            end
            RUN: if (!w_in_range) r_addr_err <= 1'b1;
               else if (i_mem_rdata == HALT_WORD) r_state <= HALTED;
            default: ;
         endcase
      end
   end

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [31:0] r_cksum;
   always_ff @(posedge i_clk) begin
      if (i_reset || i_load_start) r_cksum <= '0;
      else if (w_wr) r_cksum <= r_cksum ^ w_word;
   end
   assign o_load_checksum = r_cksum;
`else
   assign o_load_checksum = 32'h0;
`endif
endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb_imem_load_ctrl: table vectors, directed corner sequences and randomized loads/fetches
// checked against a word-level reference image of the program memory.
`timescale 1ns/1ps
module tb_imem_load_ctrl;
   localparam int          DEPTH = 64;
   localparam logic [31:0] HALT  = 32'hB4221820;
   localparam logic [31:0] NOP   = 32'h00000020;

   logic        clk = 1'b0;
   logic        reset, load_start, rx_valid, rx_ready, cpu_stall, cpu_hold_reset, mem_we, load_err, addr_err;
   logic [7:0]  rx_data;
   logic [31:0] fetch_addr, inst_out, mem_wdata, mem_rdata, load_checksum;
   logic [5:0]  mem_addr;
   logic [1:0]  state_out;
   logic        b_rx_ready, b_cpu_stall, b_cpu_hold_reset, b_mem_we, b_load_err, b_addr_err;
   logic [31:0] b_inst_out, b_mem_wdata, b_load_checksum;
   logic [5:0]  b_mem_addr;
   logic [1:0]  b_state_out;

   logic [31:0] mem [DEPTH];
   logic [31:0] ref_img [DEPTH];
   logic [31:0] ref_cks;
   logic        exp_aerr;
   logic [5:0]  wa_q [$];
   logic [31:0] wd_q [$];
   int          total = 0, bad = 0;

   typedef struct {
      logic        ls, v;
      logic [7:0]  d;
      logic [1:0]  st;
      logic        rdy, we;
      logic [5:0]  wa;
      logic [31:0] wd;
   } vec_t;
   vec_t tv [19];

   imem_load_ctrl dut (
      .i_clk(clk), .i_reset(reset), .i_load_start(load_start), .i_rx_data(rx_data),
      .i_rx_valid(rx_valid), .o_rx_ready(rx_ready), .i_fetch_addr(fetch_addr),
      .o_inst_out(inst_out), .o_cpu_stall(cpu_stall), .o_cpu_hold_reset(cpu_hold_reset),
      .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
      .o_state_out(state_out), .o_load_err(load_err), .o_addr_err(addr_err),
      .o_load_checksum(load_checksum));

   imem_load_ctrl #(.BOOT_RUN(1'b1)) dut_boot (
      .i_clk(clk), .i_reset(reset), .i_load_start(1'b0), .i_rx_data(8'h00),
      .i_rx_valid(1'b0), .o_rx_ready(b_rx_ready), .i_fetch_addr(32'h0),
      .o_inst_out(b_inst_out), .o_cpu_stall(b_cpu_stall), .o_cpu_hold_reset(b_cpu_hold_reset),
      .o_mem_addr(b_mem_addr), .o_mem_we(b_mem_we), .o_mem_wdata(b_mem_wdata), .i_mem_rdata(32'h0),
      .o_state_out(b_state_out), .o_load_err(b_load_err), .o_addr_err(b_addr_err),
      .o_load_checksum(b_load_checksum));

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_ck();
`ifdef IMEM_LOAD_CHECKSUM_EN
      return ref_cks;
`else
      return 32'h0;
`endif
   endfunction

   function automatic logic [31:0] rw();
      logic [31:0] x = $urandom;
      return (x == HALT) ? (x ^ 32'h1) : x;
   endfunction

   task automatic pulse();
      load_start = 1'b1;
      rx_valid   = 1'b1;
      rx_data    = 8'($urandom);
      #1;
      chk("ls_rx_ready", rx_ready, 0);
      chk("ls_mem_we", mem_we, 0);
      tick();
      load_start = 1'b0;
      rx_valid   = 1'b0;
      chk("ls_state", state_out, 1);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit gaps);
      int n = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         tick();
      end
      rx_valid = 1'b1;
      rx_data  = d;
      #1;
      while (!rx_ready && n < 8) begin
         tick();
         n++;
      end
      if (!rx_ready) chk("rx_ready_timeout", rx_ready, 1);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic load_prog(input logic [31:0] w [$], input bit gaps, input int junk);
      pulse();
      if (junk > 0) begin
         repeat (junk) send_byte(8'($urandom), gaps);
         pulse();
      end
      wa_q.delete();
      wd_q.delete();
      foreach (w[i]) for (int b = 3; b >= 0; b--) send_byte(w[i][8*b +: 8], gaps);
      chk("wr_count", wa_q.size(), w.size());
      foreach (w[i]) if (i < wa_q.size()) begin
         chk("wr_addr", {26'h0, wa_q[i]}, i);
         chk("wr_data", wd_q[i], w[i]);
      end
      ref_cks  = 32'h0;
      exp_aerr = 1'b0;
      foreach (w[i]) begin
         ref_img[i] = w[i];
         ref_cks   ^= w[i];
      end
   endtask

   task automatic fetch(input logic [31:0] a, input logic [1:0] exp_next);
      logic in_r = a < DEPTH * 4;
      fetch_addr = a;
      #1;
      chk("inst_out", inst_out, in_r ? ref_img[a[7:2]] : NOP);
      if (!in_r) exp_aerr = 1'b1;
      tick();
      chk("fetch_state", state_out, exp_next);
      chk("addr_err", addr_err, exp_aerr);
   endtask

   initial begin
      logic [31:0] q [$];
      int n;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = 32'h0;
         ref_img[i] = 32'h0;
      end
      reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; fetch_addr = 32'h0;
      ref_cks = 32'h0; exp_aerr = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_state", state_out, 0);
      chk("rst_hold", cpu_hold_reset, 1);
      chk("rst_stall", cpu_stall, 1);
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_inst", inst_out, NOP);
      chk("rst_load_err", load_err, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_cksum", load_checksum, 0);
      chk("rst_we", mem_we, 0);
      chk("boot_state", b_state_out, 2);
      chk("boot_stall", b_cpu_stall, 0);
      chk("boot_hold", b_cpu_hold_reset, 0);

      tv[0]  = '{1'b1, 1'b1, 8'hFF, 2'd0, 1'b0, 1'b0, 6'd0, 32'h0};
      tv[1]  = '{1'b0, 1'b1, 8'h8C, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[2]  = '{1'b0, 1'b1, 8'h01, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[3]  = '{1'b0, 1'b1, 8'h00, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[4]  = '{1'b0, 1'b1, 8'h00, 2'd1, 1'b1, 1'b1, 6'd0, 32'h8C010000};
      tv[5]  = '{1'b0, 1'b1, 8'hB4, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[6]  = '{1'b0, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[7]  = '{1'b0, 1'b1, 8'h18, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[8]  = '{1'b0, 1'b1, 8'h20, 2'd1, 1'b1, 1'b1, 6'd1, HALT};
      tv[9]  = '{1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0, 6'd0, 32'h0};
      tv[10] = '{1'b1, 1'b1, 8'h11, 2'd2, 1'b0, 1'b0, 6'd0, 32'h0};
      tv[11] = '{1'b0, 1'b1, 8'h11, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[12] = '{1'b0, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[13] = '{1'b1, 1'b1, 8'h33, 2'd1, 1'b0, 1'b0, 6'd0, 32'h0};
      tv[14] = '{1'b0, 1'b1, 8'hAA, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[15] = '{1'b0, 1'b1, 8'hBB, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[16] = '{1'b0, 1'b1, 8'hCC, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      tv[17] = '{1'b0, 1'b1, 8'hDD, 2'd1, 1'b1, 1'b1, 6'd0, 32'hAABBCCDD};
      tv[18] = '{1'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b0, 6'd0, 32'h0};
      for (int i = 0; i < 19; i++) begin
         load_start = tv[i].ls;
         rx_valid   = tv[i].v;
         rx_data    = tv[i].d;
         #1;
         chk($sformatf("tv%0d_state", i), state_out, tv[i].st);
         chk($sformatf("tv%0d_rdy", i), rx_ready, tv[i].rdy);
         chk($sformatf("tv%0d_we", i), mem_we, tv[i].we);
         if (tv[i].we) begin
            chk($sformatf("tv%0d_wa", i), mem_addr, tv[i].wa);
            chk($sformatf("tv%0d_wd", i), mem_wdata, tv[i].wd);
         end
         tick();
         if (i == 9) begin
            ref_cks = 32'h8C010000 ^ HALT;
            chk("tv_run_hold", cpu_hold_reset, 0);
            chk("tv_mem0", mem[0], 32'h8C010000);
            chk("tv_mem1", mem[1], HALT);
            chk("tv_cksum", load_checksum, exp_ck());
         end
      end
      load_start = 1'b0;
      rx_valid   = 1'b0;
      chk("restart_mem0", mem[0], 32'hAABBCCDD);

      q = '{32'h20010002, HALT};
      load_prog(q, 1'b0, 0);
      chk("prog_state", state_out, 2);
      fetch(32'h0, 2'd2);
      fetch(32'h4, 2'd3);
      #1;
      chk("halt_stall", cpu_stall, 1);
      chk("halt_inst", inst_out, NOP);
      chk("halt_hold", cpu_hold_reset, 0);

      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back(rw());
      load_prog(q, 1'b1, 0);
      chk("ovf_state", state_out, 0);
      chk("ovf_load_err", load_err, 1);
      chk("ovf_hold", cpu_hold_reset, 1);
      for (int i = 0; i < 4; i++) begin
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
         #1;
         chk("ovf_rx_ready", rx_ready, 0);
         chk("ovf_we", mem_we, 0);
         tick();
      end
      rx_valid = 1'b0;
      chk("ovf_writes", wa_q.size(), DEPTH);

      q = '{rw(), HALT};
      load_prog(q, 1'b1, 0);
      chk("reload_load_err", load_err, 0);
      chk("reload_state", state_out, 2);
      fetch(32'hFC, 2'd2);
      fetch(32'h100, 2'd2);
      fetch(32'h0, 2'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_addr_err", addr_err, 0);
      chk("rst2_state", state_out, 0);

      for (int it = 0; it < 6; it++) begin
         if (it == 0) begin
            pulse();
            for (int b = 0; b < 5; b++) send_byte(8'($urandom), 1'b1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("midrst_state", state_out, 0);
            chk("midrst_rdy", rx_ready, 0);
         end
         n = $urandom_range(1, 8);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(rw());
         q.push_back(HALT);
         load_prog(q, 1'b1, $urandom_range(0, 3));
         chk("rnd_state", state_out, 2);
         chk("rnd_load_err", load_err, 0);
         chk("rnd_cksum", load_checksum, exp_ck());
         repeat (8) begin
            if ($urandom_range(0, 3) == 0) fetch($urandom | 32'h100, 2'd2);
            else fetch(32'($urandom_range(0, n - 1) * 4 + $urandom_range(0, 3)), 2'd2);
         end
         fetch(32'(n * 4), 2'd3);
         chk("rnd_halt_inst", inst_out, NOP);
         chk("rnd_halt_cksum", load_checksum, exp_ck());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller that owns the instruction-memory port and shares it between two users: a byte-serial program loader (UART/debug side) and the CPU fetch stage.
- During load it assembles 32-bit words and writes them into instruction memory while holding the CPU in reset.
- After load it hands the read port to fetch, and it parks the CPU when the HALT word is fetched.
- Sits between IF-stage PC logic, the UART receiver and the instruction memory array.

Parameters:
- DEPTH, 64, instruction memory depth in words; a power of two.
- ADDR_W, 6, word-address width, equal to log2(DEPTH).
- HALT_WORD, 32'hB4221820, program terminator and fetch-halt opcode.
- NOP_WORD, 32'h00000020, ADD R0,R0,R0; returned to the CPU whenever fetch is not live.
- BOOT_RUN, 0, value 1 makes reset enter RUN directly (memory preloaded from file); value 0 makes reset enter IDLE.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- load_start  in  1  single-cycle pulse; begins or restarts a program load.
- rx_data  in  8  loader byte, MSB-first within each word.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- fetch_addr  in  32  byte address from PC.
- inst_out  out  32  instruction to the IF stage.
- cpu_stall  out  1  freezes PC/pipeline.
- cpu_hold_reset  out  1  holds the CPU core in reset.
- mem_addr  out  ADDR_W  word address to the memory.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read data at mem_addr.
- state_out  out  2  IDLE=0, LOAD=1, RUN=2, HALTED=3.
- load_err  out  1  sticky: program overflowed DEPTH without a HALT_WORD.
- addr_err  out  1  sticky: fetch_addr ≥ DEPTH*4 while in RUN.
- load_checksum  out  32  see Optional Feature.

Behaviour:
- Reset values:
  - state = RUN if BOOT_RUN else IDLE.
  - wr_ptr = 0, byte_cnt = 0, word_buf = 0.
  - load_err = 0, addr_err = 0, load_checksum = 0.
- Combinational outputs:
  - rx_ready = (state==LOAD) && !load_start.
  - cpu_hold_reset = (state==IDLE || state==LOAD).
  - cpu_stall = (state != RUN).
  - mem_addr = wr_ptr in LOAD; fetch_addr[ADDR_W+1:2] otherwise.
  - inst_out:
    - RUN with fetch in range: mem_rdata.
    - RUN with fetch_addr ≥ DEPTH*4: NOP_WORD.
    - all other states: NOP_WORD.
  - fetch_addr[1:0] is ignored.
- IDLE: waits. load_start → LOAD.
- LOAD:
  - Each accepted byte gives word_buf ← {word_buf[23:0], rx_data} and byte_cnt+1 (mod 4).
  - On the 4th accepted byte (byte_cnt==3), in that same cycle:
    - mem_we = 1;
    - mem_wdata = {word_buf[23:0], rx_data};
    - mem_addr = wr_ptr.
  - Next edge: wr_ptr+1.
  - mem_we = 0 in every other cycle and state.
  - If the written word == HALT_WORD → RUN next cycle; the CPU leaves reset with PC at 0.
  - Else if wr_ptr == DEPTH-1 → load_err = 1, IDLE next cycle.
  - Latency: byte 4 accepted at cycle N → memory written at edge N, state RUN at N+1.
- RUN:
  - If fetch is in range and mem_rdata == HALT_WORD → HALTED next cycle. The HALT word itself is delivered to the CPU that cycle.
  - Out-of-range fetch sets addr_err, returns NOP_WORD, and the state stays RUN.
- HALTED: stall asserted; exit only via load_start (→ LOAD) or reset.
- load_start in any state:
  - Clears wr_ptr, byte_cnt and word_buf; next state is LOAD.
  - A partial word is discarded.
  - load_err and addr_err clear on load_start.
  - A byte presented in the same cycle as load_start is not accepted (rx_ready = 0).
- Reset asserted mid-load: the load is abandoned. Memory contents already written are not cleared.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - load_checksum ← load_checksum XOR written word on every LOAD write, HALT_WORD included.
  - Cleared by reset and by load_start.
  - Holds its value through RUN/HALTED.
- Undefined: load_checksum tied to 32'h0 and no XOR logic is built.

Test Plan:
- BOOT_RUN=0, pulse load_start, stream bytes 8C 01 00 00 | B4 22 18 20 → writes at addr 0 = 8C010000 and addr 1 = B4221820; state RUN one cycle after the last byte; cpu_hold_reset falls; checksum = 38231820 when enabled.
- RUN with memory {0:20010002, 1:B4221820}, fetch_addr 0 then 4 → inst_out 20010002 then B4221820; state HALTED next cycle; cpu_stall=1; inst_out = 00000020.
- DEPTH=64, stream 64 non-HALT words → 64 writes, load_err=1, state IDLE, no further mem_we.
- Mid-word load_start after 2 bytes, then 4 bytes AA BB CC DD → single write of AABBCCDD at addr 0; load_start cycle shows rx_ready=0.
- RUN, fetch_addr = 0x100 (DEPTH=64) → inst_out 00000020, addr_err=1 sticky, state stays RUN; reset → addr_err=0, state IDLE.
- rx_valid toggling randomly with gaps during LOAD → assembled words identical to the gap-free case; reset asserted mid-stream → IDLE, wr_ptr=0 next cycle.
